// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_RR_EN for round-robin grant; by default requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_sel,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_out,
  output logic               resp_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_select,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             winner;
  logic             handshake;

  assign handshake = (state_q == RESP) && resp_ready[grant_q];

`ifdef ALU_ARB_RR_EN
  logic prio_q, prio_d;

  // Pointer names the requester that wins a tie; it moves only on a completed response.
  always_comb begin
    winner = (req_valid == 2'b11) ? prio_q : req_valid[1];
    prio_d = handshake ? ~grant_q : prio_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`else
  assign winner = ~req_valid[0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // req_ready is suppressed while reset_n is low, since reset would discard the acceptance anyway.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    res_d     = res_q;
    zero_d    = zero_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if ((|req_valid) && reset_n) begin
          req_ready = winner ? 2'b10 : 2'b01;
          grant_d   = winner;
          a_d       = winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d       = winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          sel_d     = winner ? req_sel[5:3] : req_sel[2:0];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = sel_q;
  assign resp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_out   = res_q;
  assign resp_zero  = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: operation from requester i accepted this cycle.
REQ-006 req_a  input  2*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  2*WIDTH  operand B, same packing.
REQ-008 req_sel  input  6  ALU select, requester i at bits [i*3 +: 3].
REQ-009 resp_valid  output  2  bit i: result for requester i is valid.
REQ-010 resp_ready  input  2  bit i: requester i takes its result.
REQ-011 resp_out  output  WIDTH  result of the granted operation.
REQ-012 resp_zero  output  1  zero flag of the granted operation.
REQ-013 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-014 alu_select  output  3  select driven to the shared ALU.
REQ-015 alu_out  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_select.
REQ-016 alu_zero  input  1  ALU zero flag.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement three states: IDLE, EXEC, RESP.
REQ-019 IDLE: if any req_valid bit is high, grant exactly one requester, assert its req_ready bit for that cycle only, latch its a/b/sel, go to EXEC; otherwise stay in IDLE.
REQ-020 req_ready SHALL be zero in EXEC and RESP; at most one req_ready bit high per cycle.
REQ-021 EXEC: alu_a/alu_b/alu_select SHALL drive the latched operands; at the clock edge ending EXEC, alu_out and alu_zero SHALL be captured into result registers; go to RESP.
REQ-022 RESP: resp_valid bit of the granted requester SHALL be high, other bit low; resp_out/resp_zero SHALL hold the captured values, stable until handshake.
REQ-023 RESP: when resp_ready of the granted requester is high, return to IDLE next cycle; resp_ready of the non-granted requester SHALL be ignored.
REQ-024 Latency: acceptance in cycle N -> resp_valid high from cycle N+2; minimum spacing between acceptances 3 cycles.
REQ-025 In IDLE and RESP, alu_* outputs SHALL hold the last latched operands (no glitching to requester inputs).
REQ-026 req_sel SHALL be forwarded unmodified, including value 7; no decoding inside this block.
REQ-027 Grant priority: see Configuration; the priority pointer SHALL update only on a completed response handshake.
REQ-028 Requester inputs changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-029 With reset_n low at a rising edge: state IDLE, req_ready 0, resp_valid 0, resp_out 0, resp_zero 0, alu_a/alu_b 0, alu_select 0, busy 0, priority pointer to requester 0.
REQ-030 Reset mid-operation SHALL drop the in-flight operation; no response is issued for it.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin; after a completed response for requester i, requester 1-i has priority on the next simultaneous request.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-033 Reset, req0 a=1 b=1 sel=0 -> req_ready=01 in cycle N, resp_valid=01 at N+2, resp_out equals ALU result for sel 0, zero flag matches.
REQ-034 req1 a=5 b=5 sel=1 (subtract) -> resp_valid=10, resp_out=0, resp_zero=1.
REQ-035 Both valid continuously, 4 transactions with RR_EN -> grant order 0,1,0,1; without -> 0,0,0,0.
REQ-036 Hold resp_ready low 5 cycles in RESP -> resp_valid, resp_out stable, req_ready stays 00, busy=1.
REQ-037 Change req0 operands one cycle after acceptance -> response reflects originally accepted values.
REQ-038 Pull reset_n low during EXEC -> next cycle all outputs at reset values, no resp_valid ever issued for that operation.
